// File: rtl/signmag_pkg.sv
// Shared definitions for the sign-magnitude reconstruction datapath:
// default width, FSM state encoding and counter sizing.
package signmag_pkg;

  localparam int unsigned SM_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Bit counter needs to reach WIDTH-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int unsigned SM_CNT_W = cnt_width(SM_WIDTH);

endpackage

// File: rtl/signmag_reconstructor_full_adder.sv
// Single-bit full adder cell used by the bit-serial arithmetic.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/signmag_reconstructor.sv
// Bit-serial rebuild of a = sign ? b-d : b+d, LSB first, with range flag.
// Subtraction is b + ~d + 1 using carry-in = sign.
module signmag_reconstructor
  import signmag_pkg::*;
#(
  parameter int unsigned WIDTH = SM_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] d,
  input  logic             sign,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] a,
  output logic             range_err
);

  localparam int unsigned     CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_d;
  logic [WIDTH-1:0]   r_res;
  logic [WIDTH-1:0]   r_a;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sign;
  logic               r_carry;
  logic               r_err;
  logic               w_sum;
  logic               w_cout;
  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_res_next;

  full_adder u_fa (
    .a    (r_b[0]),
    .b    (r_d[0] ^ r_sign),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  assign w_accept   = (r_state == ST_IDLE) && start;
  assign w_last     = (r_state == ST_SHIFT) && (r_cnt == LAST);
  assign w_res_next = {w_sum, r_res[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (r_cnt == LAST) w_next = ST_DONE;
      end
      ST_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_b     <= '0;
      r_d     <= '0;
      r_res   <= '0;
      r_a     <= '0;
      r_cnt   <= '0;
      r_sign  <= 1'b0;
      r_carry <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_b     <= b;
      r_d     <= d;
      r_res   <= '0;
      r_cnt   <= '0;
      r_sign  <= sign;
      r_carry <= sign;
    end else if (r_state == ST_SHIFT) begin
      r_b     <= r_b >> 1;
      r_d     <= r_d >> 1;
      r_res   <= w_res_next;
      r_carry <= w_cout;
      r_cnt   <= r_cnt + CNT_W'(1);
      // Final bit is still in flight, so a is taken from the next-result value.
      if (w_last) begin
        r_a   <= w_res_next;
        r_err <= r_sign ? ~w_cout : w_cout;
      end
    end
  end

  assign a         = r_a;
  assign range_err = r_err;

endmodule
